// File: rtl/imem_pkg.sv
// Shared constants, loader state encoding and instruction packing for the
// instruction-memory boot loader and its testbench.
package imem_pkg;

  localparam int          ADDR_W      = 12;
  localparam int          INSTR_W     = 19;
  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int          TIMEOUT_CYC = 1024;
  localparam int          MAX_WORDS   = 1 << ADDR_W;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_CSUM
  } loader_state_t;

  // Three stream bytes, little-endian, into one instruction word.
  function automatic logic [INSTR_W-1:0] pack_instr(input logic [7:0] b0,
                                                    input logic [7:0] b1,
                                                    input logic [7:0] b2);
    return {b2[2:0], b1, b0};
  endfunction

endpackage

// File: rtl/loader_timeout_ctr.sv
// Inter-byte timeout: counts idle cycles while enabled, saturates at LIMIT
// and raises tc there; clear or disable returns it to zero.
module loader_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || !en)
      cnt <= '0;
    else if (!tc)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream program loader for the instruction memory; owns the
// memory address port while the core is held, then hands it to cpu_pc.
//
// state    | meaning
// IDLE     | waiting for SYNC, other bytes dropped
// CNT_LO/HI| word count, range-checked on the high byte
// ADDR_LO/HI| base load address
// B0/B1/B2 | instruction bytes, write issued after B2
// CSUM     | compare running XOR, then back to IDLE
module imem_boot_loader
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [ADDR_W-1:0]  cpu_pc,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_error,
  output logic [ADDR_W:0]    words_loaded
);

  loader_state_t     state;
  logic [7:0]        cnt_lo;
  logic [7:0]        addr_lo;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        b0;
  logic [7:0]        b1;
  logic [7:0]        csum;
  logic              accept;
  logic              timeout;
  logic [ADDR_W:0]   count_field;

  assign rx_ready    = ~rst;
  assign accept      = rx_valid & rx_ready;
  assign count_field = {rx_data[4:0], cnt_lo};
  assign mem_addr    = cpu_hold ? load_addr : cpu_pc;

  loader_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state != ST_IDLE),
    .tc  (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt_lo       <= '0;
      addr_lo      <= '0;
      remaining    <= '0;
      load_addr    <= '0;
      b0           <= '0;
      b1           <= '0;
      csum         <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      // Address advance trails the write pulse so the in-flight write keeps its address.
      if (mem_we) begin
        load_addr    <= load_addr + 1'b1;
        words_loaded <= words_loaded + 1'b1;
      end

      if (accept) begin
        if (state != ST_IDLE && state != ST_CSUM)
          csum <= csum ^ rx_data;

        unique case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state        <= ST_CNT_LO;
              load_done    <= 1'b0;
              load_error   <= 1'b0;
              words_loaded <= '0;
              cpu_hold     <= 1'b1;
              csum         <= '0;
            end
          end
          ST_CNT_LO: begin
            cnt_lo <= rx_data;
            state  <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            if (rx_data[7:5] != 3'b000 || count_field > (ADDR_W+1)'(MAX_WORDS)) begin
              state      <= ST_IDLE;
              load_error <= 1'b1;
            end else begin
              remaining <= count_field;
              state     <= ST_ADDR_LO;
            end
          end
          ST_ADDR_LO: begin
            addr_lo <= rx_data;
            state   <= ST_ADDR_HI;
          end
          ST_ADDR_HI: begin
            load_addr <= {rx_data[ADDR_W-9:0], addr_lo};
            state     <= (remaining == '0) ? ST_CSUM : ST_B0;
          end
          ST_B0: begin
            b0    <= rx_data;
            state <= ST_B1;
          end
          ST_B1: begin
            b1    <= rx_data;
            state <= ST_B2;
          end
          ST_B2: begin
            if (rx_data[7:3] != 5'b00000) begin
              state      <= ST_IDLE;
              load_error <= 1'b1;
            end else begin
              mem_we    <= 1'b1;
              mem_wdata <= pack_instr(b0, b1, rx_data);
              remaining <= remaining - 1'b1;
              state     <= (remaining == (ADDR_W+1)'(1)) ? ST_CSUM : ST_B0;
            end
          end
          ST_CSUM: begin
            if (rx_data == csum) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (timeout) begin
        state      <= ST_IDLE;
        load_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for the boot loader: stimulus queues expected writes,
// a negedge monitor pops and checks them on every mem_we pulse.
module tb_imem_boot_loader;
  import imem_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic [ADDR_W-1:0]  cpu_pc;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_hold;
  logic               load_done;
  logic               load_error;
  logic [ADDR_W:0]    words_loaded;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] frame[$];
  int         n_vec  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .cpu_pc       (cpu_pc),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      wr_t e;
      check("we_while_hold", 32'(cpu_hold), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic new_frame(input logic [15:0] count, input logic [15:0] base);
    frame.delete();
    frame.push_back(SYNC_BYTE);
    frame.push_back(count[7:0]);
    frame.push_back(count[15:8]);
    frame.push_back(base[7:0]);
    frame.push_back(base[15:8]);
  endtask

  task automatic add_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    wr_t e;
    frame.push_back(b0);
    frame.push_back(b1);
    frame.push_back(b2);
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Sends the built frame followed by its checksum XOR corrupt.
  task automatic send_frame(input logic [7:0] corrupt, input bit with_csum);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < frame.size(); i++) x ^= frame[i];
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i]);
    if (with_csum) send_byte(x ^ corrupt);
    go_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic hold, input logic [ADDR_W:0] words);
    check({tag, "_done"},  32'(load_done),    32'(done));
    check({tag, "_error"}, 32'(load_error),   32'(err));
    check({tag, "_hold"},  32'(cpu_hold),     32'(hold));
    check({tag, "_words"}, 32'(words_loaded), 32'(words));
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    cpu_pc   = 12'h123;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check_status("reset", 1'b0, 1'b0, 1'b1, 13'd0);
    check("reset_we", 32'(mem_we), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'h000);
    check("rx_ready", 32'(rx_ready), 32'd1);

    // Good frame at base 3
    new_frame(16'd2, 16'h0003);
    add_word(8'h00, 8'h12, 8'h05, 12'd3, 19'h51200);
    add_word(8'hFF, 8'hFF, 8'h07, 12'd4, 19'h7FFFF);
    send_frame(8'h00, 1'b1);
    check_status("good", 1'b1, 1'b0, 1'b0, 13'd2);
    check("pc_mux_a", 32'(mem_addr), 32'h123);
    cpu_pc = 12'h456;
    #1;
    check("pc_mux_b", 32'(mem_addr), 32'h456);

    // Same frame, bad checksum
    new_frame(16'd2, 16'h0003);
    add_word(8'h00, 8'h12, 8'h05, 12'd3, 19'h51200);
    add_word(8'hFF, 8'hFF, 8'h07, 12'd4, 19'h7FFFF);
    send_frame(8'h01, 1'b1);
    check_status("badcsum", 1'b0, 1'b1, 1'b1, 13'd2);

    // Address wrap 4095 -> 0, base[15:12] ignored
    new_frame(16'd2, 16'hFFFF);
    add_word(8'h34, 8'h12, 8'h01, 12'hFFF, 19'h11234);
    add_word(8'hAB, 8'hCD, 8'h02, 12'h000, 19'h2CDAB);
    send_frame(8'h00, 1'b1);
    check_status("wrap", 1'b1, 1'b0, 1'b0, 13'd2);

    // Bad B2 on second word: first written, second dropped
    new_frame(16'd2, 16'h0010);
    add_word(8'h01, 8'h02, 8'h03, 12'h010, 19'h30201);
    frame.push_back(8'hAA);
    frame.push_back(8'hBB);
    frame.push_back(8'h09);
    send_frame(8'h00, 1'b0);
    check_status("badb2", 1'b0, 1'b1, 1'b1, 13'd1);

    // Empty frame
    new_frame(16'd0, 16'h0040);
    send_frame(8'h00, 1'b1);
    check_status("empty", 1'b1, 1'b0, 1'b0, 13'd0);

    // Count 4097 and count with bit 13 set both abort at the count field
    new_frame(16'd4097, 16'h0000);
    send_frame(8'h00, 1'b0);
    check_status("cnt4097", 1'b0, 1'b1, 1'b1, 13'd0);
    new_frame(16'h2001, 16'h0000);
    send_frame(8'h00, 1'b0);
    check_status("cntbit13", 1'b0, 1'b1, 1'b1, 13'd0);

    // Count 4096 is legal; then the frame stalls in B0 and times out
    new_frame(16'd4096, 16'h0000);
    send_frame(8'h00, 1'b0);
    check("cnt4096_ok", 32'(load_error), 32'd0);
    repeat (1100) @(negedge clk);
    check("cnt4096_tmo", 32'(load_error), 32'd1);

    // Stall after CNT_HI: no abort before 1024 idle cycles, abort just after
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    send_byte(8'h00);
    go_idle();
    repeat (1015) @(posedge clk);
    @(negedge clk);
    check("tmo_early", 32'(load_error), 32'd0);
    repeat (20) @(negedge clk);
    check_status("tmo", 1'b0, 1'b1, 1'b1, 13'd0);

    // Recovery frame clears the error
    new_frame(16'd1, 16'h0020);
    add_word(8'h7F, 8'h00, 8'h00, 12'h020, 19'h0007F);
    send_frame(8'h00, 1'b1);
    check_status("recover", 1'b1, 1'b0, 1'b0, 13'd1);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
